// File: rtl/mic_rd_mux.sv
// rtl/mic_rd_mux.sv - read-data mux: override registers on address hit, tag memory with timeout on miss
module mic_rd_mux #(
    parameter int              AW       = 6,
    parameter int              DW       = 16,
    parameter int              NCH      = 4,
    parameter logic [NCH*AW-1:0] OVR_ADDR = {6'h0A, 6'h09, 6'h08, 6'h07},
    parameter int              TO_CYC   = 16,
    parameter logic [DW-1:0]   ERR_VAL  = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RD_REQ,
    input  logic [AW-1:0]     A,
    input  logic [DW-1:0]     DBO,
    input  logic              DBO_VLD,
    input  logic [NCH*DW-1:0] TVAL,
    output logic [DW-1:0]     DATA_RD,
    output logic              RD_ACK,
    output logic              RD_ERR,
    output logic              BUSY
);

    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          hit;
    logic [DW-1:0] hit_val;

    // Scan from the top channel down so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_val = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (A == OVR_ADDR[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_val = TVAL[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (RD_REQ) begin
                    if (hit) begin
                        data_d = hit_val;
                        ack_d  = 1'b1;
                    end else begin
                        state_d = WAIT_MEM;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_MEM: begin
                // Memory data takes priority over a timeout landing on the same edge.
                if (DBO_VLD) begin
                    data_d  = DBO;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = ERR_VAL;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign DATA_RD = data_q;
    assign RD_ACK  = ack_q;
    assign RD_ERR  = err_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_mic_rd_mux.sv
// tb/tb_mic_rd_mux.sv - directed self-checking bench for mic_rd_mux
module tb_mic_rd_mux;

    logic        CLK;
    logic        RST_N;
    logic        RD_REQ;
    logic [5:0]  A;
    logic [15:0] DBO;
    logic        DBO_VLD;
    logic [63:0] TVAL;
    logic [15:0] DATA_RD;
    logic        RD_ACK;
    logic        RD_ERR;
    logic        BUSY;

    int n_cmp;
    int n_bad;

    mic_rd_mux dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .RD_REQ (RD_REQ),
        .A      (A),
        .DBO    (DBO),
        .DBO_VLD(DBO_VLD),
        .TVAL   (TVAL),
        .DATA_RD(DATA_RD),
        .RD_ACK (RD_ACK),
        .RD_ERR (RD_ERR),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; RD_REQ = 1'b1; A = 6'h07; DBO = '0; DBO_VLD = 1'b0;
        TVAL = {16'hA00A, 16'h9009, 16'h8008, 16'h1234};
        tick(); tick();
        n_cmp++; if (DATA_RD !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h exp 0000", DATA_RD); end
        n_cmp++; if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b exp 0", RD_ACK); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", BUSY); end
        n_cmp++; if (RD_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", RD_ERR); end
        RD_REQ = 1'b0; RST_N = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        A = 6'h07; RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        n_cmp++; if (DATA_RD !== 16'h1234) begin n_bad++; $display("FAIL hit_data: got %h exp 1234", DATA_RD); end
        n_cmp++; if (RD_ACK !== 1'b1) begin n_bad++; $display("FAIL hit_ack: got %b exp 1", RD_ACK); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL hit_busy: got %b exp 0", BUSY); end
        TVAL[15:0] = 16'h5555;
        tick();
        n_cmp++; if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL hit_ack_pulse: got %b exp 0", RD_ACK); end
        n_cmp++; if (DATA_RD !== 16'h1234) begin n_bad++; $display("FAIL hit_hold: got %h exp 1234", DATA_RD); end
        TVAL[15:0] = 16'h7007;
    endtask

    task automatic test_miss();
        A = 6'h00; RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (BUSY !== 1'b1 || RD_ACK !== 1'b0) begin n_bad++; $display("FAIL miss_wait%0d: busy %b ack %b exp busy 1 ack 0", k, BUSY, RD_ACK); end
            if (k < 2) tick();
        end
        DBO = 16'hBEEF; DBO_VLD = 1'b1;
        tick();
        DBO_VLD = 1'b0;
        n_cmp++; if (DATA_RD !== 16'hBEEF) begin n_bad++; $display("FAIL miss_data: got %h exp beef", DATA_RD); end
        n_cmp++; if (RD_ACK !== 1'b1 || RD_ERR !== 1'b0) begin n_bad++; $display("FAIL miss_ack: ack %b err %b exp 1 0", RD_ACK, RD_ERR); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL miss_busy_end: got %b exp 0", BUSY); end
        DBO = 16'h1111; DBO_VLD = 1'b1;
        tick();
        DBO_VLD = 1'b0;
        n_cmp++; if (RD_ACK !== 1'b0 || DATA_RD !== 16'hBEEF) begin n_bad++; $display("FAIL idle_vld_ignored: ack %b data %h exp 0 beef", RD_ACK, DATA_RD); end
    endtask

    task automatic test_timeout();
        int n;
        A = 6'h00; RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        n = 0;
        while (RD_ACK !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL timeout_cycles: got %0d exp 16", n); end
        n_cmp++; if (DATA_RD !== 16'hFFFF) begin n_bad++; $display("FAIL timeout_data: got %h exp ffff", DATA_RD); end
        n_cmp++; if (RD_ERR !== 1'b1 || BUSY !== 1'b0) begin n_bad++; $display("FAIL timeout_err: err %b busy %b exp 1 0", RD_ERR, BUSY); end
        tick();
        n_cmp++; if (RD_ERR !== 1'b0 || RD_ACK !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: err %b ack %b exp 0 0", RD_ERR, RD_ACK); end

        RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        n_cmp++; if (BUSY !== 1'b1 || RD_ACK !== 1'b0) begin n_bad++; $display("FAIL timeout_edge_pre: busy %b ack %b exp 1 0", BUSY, RD_ACK); end
        DBO = 16'hCAFE; DBO_VLD = 1'b1;
        tick();
        DBO_VLD = 1'b0;
        n_cmp++; if (DATA_RD !== 16'hCAFE || RD_ACK !== 1'b1 || RD_ERR !== 1'b0) begin n_bad++; $display("FAIL timeout_edge_data: data %h ack %b err %b exp cafe 1 0", DATA_RD, RD_ACK, RD_ERR); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  addrs [4];
        logic [15:0] exps  [4];
        addrs = '{6'h07, 6'h08, 6'h09, 6'h0A};
        exps  = '{16'h7007, 16'h8008, 16'h9009, 16'hA00A};
        TVAL = {16'hA00A, 16'h9009, 16'h8008, 16'h7007};
        RD_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            A = addrs[k];
            tick();
            n_cmp++; if (RD_ACK !== 1'b1 || DATA_RD !== exps[k]) begin n_bad++; $display("FAIL b2b_hit%0d: ack %b data %h exp 1 %h", k, RD_ACK, DATA_RD, exps[k]); end
        end
        RD_REQ = 1'b0;
        tick();
        n_cmp++; if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: got %b exp 0", RD_ACK); end

        A = 6'h00; RD_REQ = 1'b1;
        tick();
        A = 6'h07;
        tick();
        n_cmp++; if (RD_ACK !== 1'b0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL wait_req_ignored: ack %b busy %b exp 0 1", RD_ACK, BUSY); end
        DBO = 16'h0DD0; DBO_VLD = 1'b1;
        tick();
        DBO_VLD = 1'b0;
        n_cmp++; if (RD_ACK !== 1'b1 || DATA_RD !== 16'h0DD0) begin n_bad++; $display("FAIL wait_then_data: ack %b data %h exp 1 0dd0", RD_ACK, DATA_RD); end
        tick();
        RD_REQ = 1'b0;
        n_cmp++; if (RD_ACK !== 1'b1 || DATA_RD !== 16'h7007) begin n_bad++; $display("FAIL held_req_accept: ack %b data %h exp 1 7007", RD_ACK, DATA_RD); end
        tick();
        n_cmp++; if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL no_extra_ack: got %b exp 0", RD_ACK); end
    endtask

    task automatic test_reset_mid_wait();
        A = 6'h01; RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL rmw_busy: got %b exp 1", BUSY); end
        RST_N = 1'b0; DBO = 16'h1111; DBO_VLD = 1'b1;
        tick();
        RST_N = 1'b1; DBO_VLD = 1'b0;
        n_cmp++; if (RD_ACK !== 1'b0 || BUSY !== 1'b0 || DATA_RD !== 16'h0000) begin n_bad++; $display("FAIL rmw_reset: ack %b busy %b data %h exp 0 0 0000", RD_ACK, BUSY, DATA_RD); end
        DBO_VLD = 1'b1;
        tick();
        DBO_VLD = 1'b0;
        n_cmp++; if (RD_ACK !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL rmw_idle: ack %b busy %b exp 0 0", RD_ACK, BUSY); end
        A = 6'h09; RD_REQ = 1'b1;
        tick();
        RD_REQ = 1'b0;
        n_cmp++; if (RD_ACK !== 1'b1 || DATA_RD !== 16'h9009) begin n_bad++; $display("FAIL rmw_hit: ack %b data %h exp 1 9009", RD_ACK, DATA_RD); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_hit();
        test_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
